fir_filter_3x3_param: RTL

//  Parametrised 3x3 2D convolution on a raster luma stream. Two line buffers feed a 3x3 window.

---
 rtl/fir_filter_3x3_param_if.sv | 33 +++
 rtl/fir_filter_3x3_param.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_3x3_param_if.sv
// Video/kernel-load bundle for the 3x3 luma filter.
// The master drives the raster stream and the kernel shadow writes. The slave
// (the filter) returns the filtered RGB triplet and the delay-matched syncs.
interface fir_filter_3x3_param_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 4
);
  logic [DATA_W-1:0]        y_i;
  logic                     dv_i;
  logic                     hs_i;
  logic                     vs_i;
  logic                     coef_we_i;
  logic [3:0]               coef_addr_i;
  logic signed [COEF_W-1:0] coef_data_i;
  logic [3:0]               shift_i;
  logic                     border_i;
  logic [DATA_W-1:0]        r_o;
  logic [DATA_W-1:0]        g_o;
  logic [DATA_W-1:0]        b_o;
  logic                     dv_o;
  logic                     hs_o;
  logic                     vs_o;

  modport master (
    output y_i, dv_i, hs_i, vs_i, coef_we_i, coef_addr_i, coef_data_i, shift_i, border_i,
    input  r_o, g_o, b_o, dv_o, hs_o, vs_o
  );

  modport slave (
    input  y_i, dv_i, hs_i, vs_i, coef_we_i, coef_addr_i, coef_data_i, shift_i, border_i,
    output r_o, g_o, b_o, dv_o, hs_o, vs_o
  );
endinterface

// File: rtl/fir_filter_3x3_param.sv
// 3x3 signed-kernel convolution on a raster luma stream.
// Two ping-pong line buffers (read-before-write) supply rows r-2 and r-1, the
// live input supplies row r, and column history registers complete the window.
// The kernel is written to a shadow bank and copied to the active bank only at
// the vs rising edge, together with the shift amount, so a frame is filtered
// with a single kernel. Syncs and dv are delayed exactly PIPE clocks.
module fir_filter_3x3_param #(
  parameter int DATA_W   = 8,
  parameter int MAX_COLS = 1600,
  parameter int COEF_W   = 4,
  parameter int PIPE     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fir_filter_3x3_param_if.slave vid
);

  localparam int ACC_W  = DATA_W + COEF_W + 5;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int COL_W  = $clog2(MAX_COLS + 1);
  localparam int IDX_W  = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int ROW_W  = 11;
  localparam int NDLY   = PIPE - 3;

  localparam logic [COL_W-1:0]         COL_MAX  = COL_W'(MAX_COLS);
  localparam logic [ROW_W-1:0]         ROW_MAX  = '1;
  localparam logic signed [ACC_W-1:0]  PIX_MAX  = ACC_W'((1 << DATA_W) - 1);
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1);

  // Unsigned pixel times signed tap; the pixel is zero-extended first.
  function automatic logic signed [PROD_W-1:0] tap_mul(
    input logic [DATA_W-1:0]        pix,
    input logic signed [COEF_W-1:0] coef
  );
    logic signed [DATA_W:0]   pix_s;
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;
    pix_s = signed'({1'b0, pix});
    a     = PROD_W'(pix_s);
    b     = PROD_W'(coef);
    return a * b;
  endfunction

  // Clamp a shifted accumulator into the unsigned pixel range.
  function automatic logic [DATA_W-1:0] clamp_pix(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1]) return '0;
    if (v > PIX_MAX) return '1;
    return v[DATA_W-1:0];
  endfunction

  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic                     sel_q, sel_d;
  logic                     dv_prev_q, dv_prev_d;
  logic                     vs_prev_q, vs_prev_d;
  logic [3:0]               shift_q, shift_d;
  logic signed [COEF_W-1:0] shadow_q [9];
  logic signed [COEF_W-1:0] shadow_d [9];
  logic signed [COEF_W-1:0] coef_q   [9];
  logic signed [COEF_W-1:0] coef_d   [9];
  logic                     dv_fall;
  logic                     vs_rise;

  // Raster counters, buffer swap and kernel shadow/active next state.
  always_comb begin
    dv_fall   = dv_prev_q & ~vid.dv_i;
    vs_rise   = vid.vs_i & ~vs_prev_q;
    dv_prev_d = vid.dv_i;
    vs_prev_d = vid.vs_i;
    col_d     = col_q;
    row_d     = row_q;
    sel_d     = sel_q;
    shift_d   = shift_q;
    shadow_d  = shadow_q;
    coef_d    = coef_q;
    if (vid.dv_i && (col_q != COL_MAX)) col_d = col_q + COL_W'(1);
    if (dv_fall) begin
      col_d = '0;
      sel_d = ~sel_q;
      if (row_q != ROW_MAX) row_d = row_q + ROW_W'(1);
    end
    if (vs_rise) begin
      col_d = '0;
      row_d = '0;
    end
    if (vid.coef_we_i) begin
      for (int k = 0; k < 9; k++) begin
        if (vid.coef_addr_i == 4'(k)) shadow_d[k] = vid.coef_data_i;
      end
    end
    // A write landing on the vs edge is already in shadow_d, so it is copied.
    if (vs_rise) begin
      coef_d  = shadow_d;
      shift_d = vid.shift_i;
    end
  end

  // Control state register; reset restores the identity kernel in both banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      sel_q     <= 1'b0;
      dv_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      shift_q   <= '0;
      for (int k = 0; k < 9; k++) begin
        coef_q[k]   <= (k == 4) ? COEF_ONE : '0;
        shadow_q[k] <= (k == 4) ? COEF_ONE : '0;
      end
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      sel_q     <= sel_d;
      dv_prev_q <= dv_prev_d;
      vs_prev_q <= vs_prev_d;
      shift_q   <= shift_d;
      for (int k = 0; k < 9; k++) begin
        coef_q[k]   <= coef_d[k];
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  logic             col_ok;
  logic             in_border;
  logic [IDX_W-1:0] wr_idx;

  // Per-pixel classification at the input.
  always_comb begin
    col_ok    = (col_q < COL_MAX);
    in_border = (row_q < ROW_W'(2)) || (col_q < COL_W'(2)) || !col_ok;
    wr_idx    = col_ok ? IDX_W'(col_q) : '0;
  end

  logic [DATA_W-1:0] mem_a [MAX_COLS];
  logic [DATA_W-1:0] mem_b [MAX_COLS];
  logic [DATA_W-1:0] rd_a_p0, rd_b_p0, y_p0;
  logic              sel_p0, bflag_p0, bmode_p0;
  logic [2:0]        sync_q [PIPE];

  // Stage p0: line buffer read (old contents) and write of the live pixel.
  always_ff @(posedge clk) begin
    if (vid.dv_i && col_ok) begin
      if (sel_q) mem_b[wr_idx] <= vid.y_i;
      else       mem_a[wr_idx] <= vid.y_i;
    end
    rd_a_p0  <= mem_a[wr_idx];
    rd_b_p0  <= mem_b[wr_idx];
    y_p0     <= vid.y_i;
    sel_p0   <= sel_q;
    bflag_p0 <= in_border;
    bmode_p0 <= vid.border_i;
  end

  logic              vld_p0;
  logic [DATA_W-1:0] newest_p0 [3];
  logic [DATA_W-1:0] win_p0    [9];
  logic [DATA_W-1:0] colm1_p1  [3];
  logic [DATA_W-1:0] colm2_p1  [3];

  // Window assembly: the buffer being written still holds row r-2.
  always_comb begin
    vld_p0       = sync_q[0][0];
    newest_p0[0] = sel_p0 ? rd_b_p0 : rd_a_p0;
    newest_p0[1] = sel_p0 ? rd_a_p0 : rd_b_p0;
    newest_p0[2] = y_p0;
    for (int r = 0; r < 3; r++) begin
      win_p0[r*3]     = colm2_p1[r];
      win_p0[r*3 + 1] = colm1_p1[r];
      win_p0[r*3 + 2] = newest_p0[r];
    end
  end

  logic signed [PROD_W-1:0] prod_p1 [9];
  logic [DATA_W-1:0]        y_p1;
  logic                     bflag_p1, bmode_p1;

  // Stage p1: column history shift on each valid pixel, and the nine products.
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      for (int r = 0; r < 3; r++) begin
        colm1_p1[r] <= newest_p0[r];
        colm2_p1[r] <= colm1_p1[r];
      end
    end
    for (int k = 0; k < 9; k++) prod_p1[k] <= tap_mul(win_p0[k], coef_q[k]);
    y_p1     <= y_p0;
    bflag_p1 <= bflag_p0;
    bmode_p1 <= bmode_p0;
  end

  logic signed [ACC_W-1:0] acc_c;

  // Accumulate; ACC_W has headroom for nine worst-case products.
  always_comb begin
    acc_c = '0;
    for (int k = 0; k < 9; k++) acc_c = acc_c + ACC_W'(prod_p1[k]);
  end

  logic signed [ACC_W-1:0] acc_p2;
  logic [DATA_W-1:0]       y_p2;
  logic                    bflag_p2, bmode_p2;

  // Stage p2: registered sum.
  always_ff @(posedge clk) begin
    acc_p2   <= acc_c;
    y_p2     <= y_p1;
    bflag_p2 <= bflag_p1;
    bmode_p2 <= bmode_p1;
  end

  logic signed [ACC_W-1:0] shr_p2;
  logic [DATA_W-1:0]       pix_c;

  // Shift, clamp and border substitution.
  always_comb begin
    shr_p2 = acc_p2 >>> shift_q;
    if (bflag_p2) pix_c = bmode_p2 ? y_p2 : '0;
    else          pix_c = clamp_pix(shr_p2);
  end

  logic [DATA_W-1:0] pix_q [NDLY];

  // Stage p3 onward: each stage loads only with valid data, so the last one
  // holds the most recent pixel while dv_o is low. Reset flushes to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NDLY; k++) pix_q[k] <= '0;
    end else begin
      if (sync_q[2][0]) pix_q[0] <= pix_c;
      for (int k = 1; k < NDLY; k++) begin
        if (sync_q[2 + k][0]) pix_q[k] <= pix_q[k - 1];
      end
    end
  end

  // {vs, hs, dv} delay line; dv doubles as the pipeline valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= {vid.vs_i, vid.hs_i, vid.dv_i};
      for (int k = 1; k < PIPE; k++) sync_q[k] <= sync_q[k - 1];
    end
  end

  assign vid.r_o  = pix_q[NDLY-1];
  assign vid.g_o  = pix_q[NDLY-1];
  assign vid.b_o  = pix_q[NDLY-1];
  assign vid.dv_o = sync_q[PIPE-1][0];
  assign vid.hs_o = sync_q[PIPE-1][1];
  assign vid.vs_o = sync_q[PIPE-1][2];

endmodule
